seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Parametrised multi-digit 7-segment display driver for the traffic controller countdown.
//  - Converts a binary count into BCD with a sequential double-dabble converter.
//  - Time-multiplexes NUM_DIGITS common-anode digits.
//  - Adds leading-zero blanking, per-digit decimal points, blink and overflow indication.
//  - Sits between the phase timer and the board's segment/anode pins.
// PARAMETERS
//  NUM_DIGITS   4     digits driven (1..8); digit 0 = least significant
//  VAL_W        14    width of binary input value (VAL_W <= 4*NUM_DIGITS)
//  SCAN_DIV     2048  clk cycles per digit slot (>=2)
//  BLINK_TICKS  256   scan ticks per blink half-period (>=1)
// PORTS
//  clk       in   1           system clock
//  reset     in   1           synchronous, active-high reset
//  value     in   VAL_W       binary value to display
//  load      in   1           1-cycle strobe: sample value and start conversion
//  blank_lz  in   1           1 = blank leading zero digits
//  blink_en  in   1           1 = blink whole display
//  dp_mask   in   NUM_DIGITS  1 = light decimal point of digit i
//  seg_n     out  8           segments, active-low; bit0=a..bit6=g, bit7=dp
//  an_n      out  NUM_DIGITS  digit enables, active-low, at most one low
//  busy      out  1           conversion in progress
//  overflow  out  1           last converted value > 10^NUM_DIGITS-1
// BEHAVIOUR
//  Reset (sync, highest priority, aborts any conversion):
//   - seg_n=8'hFF, an_n=all 1, busy=0, overflow=0.
//   - Digit regs=0, pending=0, scan/blink counters=0, digit index=0, blink phase=on.
//  Conversion:
//   - load sampled at edge E0 while !busy; busy=1 after E0.
//   - VAL_W shift/add-3 steps on E1..E_VAL_W.
//   - Digit regs and overflow update atomically on E_VAL_W+1; busy=0 after it, unless pending.
//   - load while busy: value captured into pending reg; a later load overwrites it (last wins).
//   - When pending is set, the next conversion starts on the completion edge; busy stays high, no gap.
//   - Overflow: every digit shows '-' (8'hBF, dp per mask); overflow=1.
//  Scan:
//   - Scan counter 0..SCAN_DIV-1. The terminal count is a tick.
//   - On each tick: index advances (wraps NUM_DIGITS-1 -> 0); seg_n and an_n reload for the new index.
//   - seg_n/an_n change only on ticks. The first tick after reset shows digit 0, i.e. SCAN_DIV cycles after reset.
//   - an_n[i]=0 only for the current index.
//   - Digit regs changed mid-slot take effect at the next tick.
//  Encoding: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 (hex, dp off).
//   - dp_mask[i]=1 forces bit7=0.
//  Leading-zero blanking:
//   - With blank_lz=1, digits above the most significant nonzero digit show segments a-g off; dp still follows dp_mask.
//   - Digit 0 is never blanked. No blanking while overflow=1.
//  Blink:
//   - Blink counter counts ticks; blink phase toggles every BLINK_TICKS ticks.
//   - blink_en=1 and phase off: an_n=all 1 at each tick.
//   - Scanning continues regardless of blink.
//   - blink_en=0: display always on; the counter keeps running.
// TESTING (SCAN_DIV=4, BLINK_TICKS=2, NUM_DIGITS=4, VAL_W=14)
//  1. Reset held 3 cycles, then released
//     -> seg_n=FF, an_n=1111 for 4 cycles; then an_n=1110, seg_n=C0.
//  2. load value=137, blank_lz=1
//     -> busy high 15 cycles.
//     -> Scan shows an_n 1110/F8, 1101/B0, 1011/F9, 0111/FF; with blank_lz=0, digit 3 shows C0.
//  3. load 9999 -> digits 9,9,9,9, overflow=0.
//     load 10000 -> all digits BF, overflow=1.
//  4. load 25, then load 42 and 57 while busy
//     -> busy continuous for 30 cycles; final display 57; 42 never shown.
//  5. blink_en=1 -> an_n alternates: 2 ticks scanning, 2 ticks 1111.
//     dp_mask=0010 -> digit 1 seg bit7=0.
//  6. reset asserted at step 7 of a conversion of 500
//     -> busy=0, display returns to the reset state; a fresh load 8 then displays 8.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multi-digit common-anode 7-segment driver: sequential double-dabble BCD conversion plus scanned display.
// Latency: VAL_W+1 cycles load-to-digits; display changes only on scan ticks (every SCAN_DIV cycles).
// Backpressure: a load while busy is parked in a single pending slot (last load wins) and starts back-to-back.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int VAL_W       = 14,
  parameter int SCAN_DIV    = 2048,
  parameter int BLINK_TICKS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VAL_W-1:0]      value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  busy,
  output logic                  overflow
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SC_W  = $clog2(SCAN_DIV);
  localparam int BL_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int ST_W  = $clog2(VAL_W + 1);

  // Largest value that fits in the display: 10^n - 1.
  function automatic logic [63:0] max_disp(input int n);
    logic [63:0] r;
    r = 64'd0;
    for (int k = 0; k < n; k++) r = r * 64'd10 + 64'd9;
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = max_disp(NUM_DIGITS);

  // Active-low a..g pattern for one BCD digit; codes above 9 render dark.
  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'd0:    enc7 = 7'h40;
      4'd1:    enc7 = 7'h79;
      4'd2:    enc7 = 7'h24;
      4'd3:    enc7 = 7'h30;
      4'd4:    enc7 = 7'h19;
      4'd5:    enc7 = 7'h12;
      4'd6:    enc7 = 7'h02;
      4'd7:    enc7 = 7'h78;
      4'd8:    enc7 = 7'h00;
      4'd9:    enc7 = 7'h10;
      default: enc7 = 7'h7F;
    endcase
  endfunction

  typedef enum logic [0:0] {S_IDLE, S_CONV} state_t;

  state_t                  state_q, state_d;
  logic                    start, commit, step_en;
  logic [VAL_W-1:0]        start_val;
  logic [VAL_W-1:0]        sh_q;
  logic [DW-1:0]           bcd_q, bcd_adj, bcd_step;
  logic [ST_W-1:0]         step_q;
  logic                    conv_ovf_q;
  logic                    pend_vld_q;
  logic [VAL_W-1:0]        pend_val_q;
  logic [DW-1:0]           dig_q;
  logic                    overflow_q;
  logic [SC_W-1:0]         scan_cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BL_W-1:0]         blink_cnt_q;
  logic                    blink_on_q;
  logic                    tick;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              cur_dig;
  logic                    cur_lz, cur_dp, zero_run;

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: run VAL_W steps, then commit; a pending or simultaneous load chains straight on.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    commit    = 1'b0;
    step_en   = 1'b0;
    start_val = load ? value : pend_val_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          start   = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (step_q == ST_W'(VAL_W)) begin
          commit = 1'b1;
          if (load || pend_vld_q) start = 1'b1;
          else                    state_d = S_IDLE;
        end else begin
          step_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bcd_step = DW'({bcd_adj, sh_q[VAL_W-1]});
  end

  // Conversion datapath and atomic publish of digits/overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q       <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      conv_ovf_q <= 1'b0;
      dig_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (start) begin
        sh_q       <= start_val;
        bcd_q      <= '0;
        step_q     <= '0;
        conv_ovf_q <= (64'(start_val) > MAX_VAL);
      end else if (step_en) begin
        sh_q   <= sh_q << 1;
        bcd_q  <= bcd_step;
        step_q <= step_q + ST_W'(1);
      end
      if (commit) begin
        dig_q      <= bcd_q;
        overflow_q <= conv_ovf_q;
      end
    end
  end

  // Single pending slot: later loads overwrite, consumed when the next conversion starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
    end else if (start) begin
      pend_vld_q <= 1'b0;
    end else if (load && state_q == S_CONV) begin
      pend_vld_q <= 1'b1;
      pend_val_q <= value;
    end
  end

  assign tick = (scan_cnt_q == SC_W'(SCAN_DIV - 1));

  // Select the digit under the scan index and decide whether it is a blankable leading zero.
  always_comb begin
    cur_dig  = 4'd0;
    cur_lz   = 1'b0;
    cur_dp   = 1'b0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (dig_q[4*i +: 4] == 4'd0);
      if (idx_q == IDX_W'(i)) begin
        cur_dig = dig_q[4*i +: 4];
        cur_lz  = zero_run && (i != 0);
        cur_dp  = dp_mask[i];
      end
    end
  end

  // Segment/anode values to load at the next tick.
  always_comb begin
    seg_d[7] = ~cur_dp;
    if (overflow_q)              seg_d[6:0] = 7'h3F;
    else if (blank_lz && cur_lz) seg_d[6:0] = 7'h7F;
    else                         seg_d[6:0] = enc7(cur_dig);
    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = (idx_q != IDX_W'(i)) || (blink_en && !blink_on_q);
    end
  end

  // Scan divider, digit index, blink phase and registered pin outputs; pins move only on ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      seg_q       <= 8'hFF;
      an_q        <= '1;
    end else begin
      scan_cnt_q <= tick ? '0 : scan_cnt_q + SC_W'(1);
      if (tick) begin
        seg_q <= seg_d;
        an_q  <= an_d;
        idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        if (blink_cnt_q == BL_W'(BLINK_TICKS - 1)) begin
          blink_cnt_q <= '0;
          blink_on_q  <= ~blink_on_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BL_W'(1);
        end
      end
    end
  end

  assign seg_n    = seg_q;
  assign an_n     = an_q;
  assign busy     = (state_q == S_CONV);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: directed plus random loads against an event-level display model.
// Every cycle compares seg_n, an_n, busy and overflow against the model.
// Model derives digits arithmetically and tick/blink timing from the cycle count since reset.
module tb_seg7_scan_driver;

  localparam int ND   = 4;
  localparam int VW   = 14;
  localparam int SD   = 4;
  localparam int BT   = 2;
  localparam int CONV = VW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [VW-1:0] value;
  logic          load;
  logic          blank_lz;
  logic          blink_en;
  logic [ND-1:0] dp_mask;
  logic [7:0]    seg_n;
  logic [ND-1:0] an_n;
  logic          busy;
  logic          overflow;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .VAL_W(VW), .SCAN_DIV(SD), .BLINK_TICKS(BT)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .blink_en(blink_en), .dp_mask(dp_mask), .seg_n(seg_n), .an_n(an_n),
    .busy(busy), .overflow(overflow)
  );

  int n_pass = 0;
  int n_fail = 0;

  // Behavioural model state.
  int         cyc;
  int         m_disp;
  bit         m_busy;
  int         m_conv_val;
  int         m_end;
  bit         m_pend;
  int         m_pend_val;
  logic [7:0] exp_seg;
  logic [3:0] exp_an;

  int         pow10 [5] = '{1, 10, 100, 1000, 10000};
  logic [6:0] enc   [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [7:0] model_seg(input int v, input int i, input bit blz, input logic [3:0] dp);
    logic [6:0] s;
    if (v > 9999)                         s = 7'h3F;
    else if (blz && i > 0 && v < pow10[i]) s = 7'h7F;
    else                                  s = enc[(v / pow10[i]) % 10];
    return {~dp[i], s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock, update the model with what the DUT saw at that edge, then compare.
  task automatic step();
    int  t, idx;
    bit  on;
    @(posedge clk);
    if (reset) begin
      cyc = 0; m_disp = 0; m_busy = 0; m_pend = 0;
      exp_seg = 8'hFF; exp_an = 4'hF;
    end else begin
      cyc++;
      if (cyc % SD == 0) begin
        t   = cyc / SD;
        idx = (t - 1) % ND;
        on  = (((t - 1) / BT) % 2) == 0;
        exp_seg = model_seg(m_disp, idx, blank_lz, dp_mask);
        exp_an  = (blink_en && !on) ? 4'hF : ~(4'b0001 << idx);
      end
      if (m_busy && cyc == m_end) begin
        m_disp = m_conv_val;
        if (load) begin
          m_conv_val = int'(value); m_end = cyc + CONV; m_pend = 0;
        end else if (m_pend) begin
          m_conv_val = m_pend_val; m_end = cyc + CONV; m_pend = 0;
        end else begin
          m_busy = 0;
        end
      end else if (load) begin
        if (m_busy) begin
          m_pend = 1; m_pend_val = int'(value);
        end else begin
          m_busy = 1; m_conv_val = int'(value); m_end = cyc + CONV;
        end
      end
    end
    #1;
    chk("seg_n", 32'(seg_n), 32'(exp_seg));
    chk("an_n", 32'(an_n), 32'(exp_an));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("overflow", 32'(overflow), 32'(m_disp > 9999));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input int v);
    value = VW'(v);
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value = '0;
    blank_lz = 1'b0; blink_en = 1'b0; dp_mask = '0;

    // Reset held, then released: dark for SCAN_DIV cycles, then digit 0 shows '0'.
    run(3);
    reset = 1'b0;
    run(10);

    // 137 with and without leading-zero blanking.
    blank_lz = 1'b1;
    do_load(137);
    run(36);
    blank_lz = 1'b0;
    run(20);

    // Largest displayable value, then first overflowing value.
    do_load(9999);
    run(35);
    blank_lz = 1'b1;
    do_load(10000);
    run(35);

    // Back-to-back loads: middle one is overwritten while pending.
    do_load(25);
    run(2);
    do_load(42);
    run(3);
    do_load(57);
    run(45);

    // Blink and decimal point.
    blink_en = 1'b1;
    dp_mask  = 4'b0010;
    run(40);
    blink_en = 1'b0;
    dp_mask  = '0;

    // Random loads, some landing while busy, with random display controls.
    for (int r = 0; r < 16; r++) begin
      blank_lz = 1'($urandom_range(0, 1));
      blink_en = 1'($urandom_range(0, 1));
      dp_mask  = 4'($urandom_range(0, 15));
      do_load((r % 3 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999)));
      run(int'($urandom_range(2, 40)));
    end
    blink_en = 1'b0;
    run(40);

    // Reset in the middle of a conversion, then a fresh load.
    do_load(500);
    run(7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(6);
    blank_lz = 1'b1;
    do_load(8);
    run(40);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
